// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus initiator: register map, status bits, FSM states
// and the baud divisor calculation.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int unsigned STAT_RDA = 0;
  localparam int unsigned STAT_TBR = 1;

  typedef enum logic [2:0] {
    StIdle,
    StCfgLo,
    StCfgHi,
    StPoll,
    StReadRx,
    StWriteTx
  } state_e;

  // Baud select 0..3 maps to 4800 << sel; divisor = clk / (16 * baud) - 1.
  function automatic logic [15:0] div_for(input logic [1:0] baud_sel,
                                          input int unsigned clk_freq);
    int unsigned baud;
    baud = 32'd4800 << baud_sel;
    return 16'(clk_freq / (32'd16 * baud) - 32'd1);
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control-side signals between the bus initiator and the SPART responder.
interface spart_driver_if;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );

endinterface

// File: rtl/sync_2ff.sv
// Multi-stage flop synchronizer for slow asynchronous inputs; resets to all zeros.
module sync_2ff #(
  parameter int unsigned Width  = 2,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor, then polls status and echoes each
// received byte back to the transmitter through a one-entry hold register.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     br_cfg_i,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus_io,
  output logic [7:0]     rx_byte_o,
  output logic           rx_strobe_o,
  output logic           busy_cfg_o
);

  localparam logic [15:0] DivTable [4] = '{
    div_for(2'd0, CLK_FREQ),
    div_for(2'd1, CLK_FREQ),
    div_for(2'd2, CLK_FREQ),
    div_for(2'd3, CLK_FREQ)
  };

  state_e      state_q, state_d;
  logic [1:0]  br_sync;
  logic [1:0]  cfg_q, cfg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_strobe_q, rx_strobe_d;
  logic        busy_q, busy_d;
  logic        s_rda_q, s_rda_d;
  logic        s_tbr_q, s_tbr_d;

  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  wdata;
  logic [15:0] div_sel;
  logic        bus_rda;
  logic        bus_tbr;
  logic        cfg_changed;
  logic        unused_status;

  sync_2ff #(
    .Width  (2),
    .Stages (SYNC_STAGES)
  ) u_br_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (br_cfg_i),
    .q_o   (br_sync)
  );

  // The rda/tbr pins are observation-only; decisions come from the status read.
  assign unused_status = bus.rda ^ bus.tbr;

  assign div_sel     = DivTable[cfg_q];
  assign cfg_changed = (br_sync != cfg_q);

  // Moore bus decode.
  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = ADDR_BUF;
    wdata  = 8'h00;
    unique case (state_q)
      StCfgLo: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DIV_LO;
        wdata  = div_sel[7:0];
      end
      StCfgHi: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DIV_HI;
        wdata  = div_sel[15:8];
      end
      StPoll: begin
        iocs   = 1'b1;
        ioaddr = ADDR_STATUS;
      end
      StReadRx: begin
        iocs   = 1'b1;
        ioaddr = ADDR_BUF;
      end
      StWriteTx: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_BUF;
        wdata  = hold_q;
      end
      default: ;
    endcase
  end

  assign bus.iocs   = iocs;
  assign bus.iorw   = iorw;
  assign bus.ioaddr = ioaddr;
  assign databus_io = (iocs && !iorw) ? wdata : 8'hzz;

  // Anything other than a clean 1 on a status bit (including X/Z) reads as 0.
  always_comb begin
    bus_rda = 1'b0;
    bus_tbr = 1'b0;
    if (databus_io[STAT_RDA] == 1'b1) bus_rda = 1'b1;
    if (databus_io[STAT_TBR] == 1'b1) bus_tbr = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rx_byte_d    = rx_byte_q;
    rx_strobe_d  = 1'b0;
    busy_d       = busy_q;
    s_rda_d      = 1'b0;
    s_tbr_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StCfgLo;
        cfg_d   = br_sync;
        busy_d  = 1'b1;
      end
      StCfgLo: begin
        state_d = StCfgHi;
      end
      StCfgHi: begin
        state_d = StPoll;
        busy_d  = 1'b0;
      end
      StPoll: begin
        s_rda_d = bus_rda;
        s_tbr_d = bus_tbr;
        // Status flags are cleared outside POLL, so each decision needs a fresh sample.
        if (cfg_changed) begin
          state_d = StCfgLo;
          cfg_d   = br_sync;
          busy_d  = 1'b1;
        end else if (hold_valid_q && s_tbr_q) begin
          state_d = StWriteTx;
        end else if (!hold_valid_q && s_rda_q) begin
          state_d = StReadRx;
        end
      end
      StReadRx: begin
        state_d      = StPoll;
        hold_d       = databus_io;
        rx_byte_d    = databus_io;
        rx_strobe_d  = 1'b1;
        hold_valid_d = 1'b1;
      end
      StWriteTx: begin
        state_d      = StPoll;
        hold_valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cfg_q        <= 2'b00;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      rx_byte_q    <= 8'h00;
      rx_strobe_q  <= 1'b0;
      busy_q       <= 1'b1;
      s_rda_q      <= 1'b0;
      s_tbr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rx_byte_q    <= rx_byte_d;
      rx_strobe_q  <= rx_strobe_d;
      busy_q       <= busy_d;
      s_rda_q      <= s_rda_d;
      s_tbr_q      <= s_tbr_d;
    end
  end

  assign rx_byte_o   = rx_byte_q;
  assign rx_strobe_o = rx_strobe_q;
  assign busy_cfg_o  = busy_q;

endmodule
